aes_decrypt_seq: RTL and testbench

//   Round sequencer for the iterative AES inverse cipher datapath. Accepts one
//   128-bit ciphertext block over a valid/ready handshake, owns the 128-bit

---
 rtl/aes_decrypt_seq.sv | 97 +++++++++
 tb/tb_aes_decrypt_seq.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_seq.sv
// Round sequencer for an iterative AES inverse cipher: owns the state register
// and steps the external round units through key indices NR down to 0.
module aes_decrypt_seq #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  output logic [3:0]   key_idx,
  output logic [0:127] state_out,
  input  logic [0:127] init_res,
  input  logic [0:127] mid_res,
  input  logic [0:127] last_res,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data,
  output logic         busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_ROUND = 3'd2;
  localparam logic [2:0] S_LAST  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [3:0] NR_IDX = 4'(NR);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $fatal(1, "aes_decrypt_seq: NR must be 10, 12 or 14 (NK=%0d)", NK);
  end

  logic [2:0]   fsm_reg;
  logic [2:0]   fsm_next;
  logic [0:127] block_reg;
  logic [3:0]   key_idx_reg;
  logic         out_valid_reg;

  always_comb begin
    fsm_next = fsm_reg;
    case (fsm_reg)
      S_IDLE:  if (in_valid) fsm_next = S_INIT;
      S_INIT:  fsm_next = S_ROUND;
      S_ROUND: if (key_idx_reg == 4'd1) fsm_next = S_LAST;
      S_LAST:  fsm_next = S_DONE;
      S_DONE:  if (out_ready) fsm_next = S_IDLE;
      default: fsm_next = S_IDLE;
    endcase
  end

  // Each non-idle state loads exactly one round result; key_idx reaches 0 on
  // entry to LAST and is never decremented again, so it cannot wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_reg       <= S_IDLE;
      block_reg     <= '0;
      key_idx_reg   <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      fsm_reg <= fsm_next;
      case (fsm_reg)
        S_IDLE: begin
          if (in_valid) begin
            block_reg   <= in_data;
            key_idx_reg <= NR_IDX;
          end
        end
        S_INIT: begin
          block_reg   <= init_res;
          key_idx_reg <= NR_IDX - 4'd1;
        end
        S_ROUND: begin
          block_reg   <= mid_res;
          key_idx_reg <= key_idx_reg - 4'd1;
        end
        S_LAST: begin
          block_reg     <= last_res;
          out_valid_reg <= 1'b1;
        end
        S_DONE: begin
          if (out_ready) out_valid_reg <= 1'b0;
        end
        default: out_valid_reg <= 1'b0;
      endcase
    end
  end

  assign in_ready  = (fsm_reg == S_IDLE);
  assign busy      = (fsm_reg != S_IDLE);
  assign key_idx   = key_idx_reg;
  assign state_out = block_reg;
  assign out_data  = block_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_aes_decrypt_seq.sv
// Bench for aes_decrypt_seq: two sequencers (NR=10, NR=14) driving a behavioural
// AES inverse round datapath, checked cycle by cycle against a transaction model.
module tb_aes_decrypt_seq;

  localparam logic [0:127] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [0:127] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:255] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [0:255] KEY256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   in_valid, out_ready, in_ready_w, out_valid_w, busy_w;
  logic [0:127] in_data [2];
  logic [3:0]   key_idx_w [2];
  logic [0:127] state_out_w [2];
  logic [0:127] out_data_w [2];
  logic [0:127] rk [2][16];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_trace [12] = '{10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 0};

  bit           m_busy [2];
  int           m_k [2];
  logic [0:127] m_exp [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- GF(2^8) / AES arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    logic [7:0] p;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b};
    return t[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return ginv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
  endfunction

  // InvShiftRows, InvSubBytes, AddRoundKey
  function automatic logic [0:127] inv_last(input logic [0:127] s, input logic [0:127] k);
    logic [0:127] t;
    int r, c;
    for (int n = 0; n < 16; n++) begin
      r = n % 4;
      c = n / 4;
      t[8*n +: 8] = inv_sbox(s[8*((((c - r + 4) % 4) * 4) + r) +: 8]);
    end
    return t ^ k;
  endfunction

  function automatic logic [0:127] inv_round(input logic [0:127] s, input logic [0:127] k);
    logic [0:127] u, o;
    logic [7:0]   a [4];
    logic [7:0]   m [4];
    logic [7:0]   b;
    m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    u = inv_last(s, k);
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = u[8*(4*c + j) +: 8];
      for (int r = 0; r < 4; r++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++) b = b ^ gmul(m[(j - r + 4) % 4], a[j]);
        o[8*(4*c + r) +: 8] = b;
      end
    end
    return o;
  endfunction

  task automatic expand(input int inst, input int nk, input logic [0:255] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        w[i] = key[32*i +: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = subw(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++) rk[inst][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic int nr_of(input int i);
    return (i == 0) ? 10 : 14;
  endfunction

  // Whole-block reference: the complete inverse cipher in one call.
  function automatic logic [0:127] aes_decrypt(input logic [0:127] ct, input int inst);
    logic [0:127] s;
    int nr;
    nr = nr_of(inst);
    s = ct ^ rk[inst][nr];
    for (int r = nr - 1; r >= 1; r--) s = inv_round(s, rk[inst][r]);
    return inv_last(s, rk[inst][0]);
  endfunction

  // ---------------- DUTs with behavioural round units ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int NRI = (gi == 0) ? 10 : 14;
    logic [0:127] st, od, ires, mres, lres;
    logic [3:0]   ki;
    logic         ir, ov, bz;

    aes_decrypt_seq #(.NK(NRI - 6), .NR(NRI)) dut (
      .clk(clk), .reset(rst),
      .in_valid(in_valid[gi]), .in_ready(ir), .in_data(in_data[gi]),
      .key_idx(ki), .state_out(st),
      .init_res(ires), .mid_res(mres), .last_res(lres),
      .out_valid(ov), .out_ready(out_ready[gi]), .out_data(od), .busy(bz)
    );

    always_comb begin
      ires = st ^ rk[gi][ki];
      mres = inv_round(st, rk[gi][ki]);
      lres = inv_last(st, rk[gi][ki]);
    end

    assign in_ready_w[gi]  = ir;
    assign out_valid_w[gi] = ov;
    assign busy_w[gi]      = bz;
    assign key_idx_w[gi]   = ki;
    assign state_out_w[gi] = st;
    assign out_data_w[gi]  = od;
  end

  task automatic chk(input string name, input int inst, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %h expected %h", name, inst, act, exp);
    end
  endtask

  // ---------------- transaction model ----------------
  // m_k counts edges since acceptance; DONE is reached after NR+1 of them.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] <= 1'b0;
        m_k[i]    <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_busy[i]) begin
          if (in_valid[i]) begin
            m_busy[i] <= 1'b1;
            m_k[i]    <= 0;
            m_exp[i]  <= aes_decrypt(in_data[i], i);
          end
        end else if (m_k[i] >= nr_of(i) + 1) begin
          if (out_ready[i]) m_busy[i] <= 1'b0;
        end else begin
          m_k[i] <= m_k[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    int   nr, ek;
    logic eov;
    for (int i = 0; i < 2; i++) begin
      nr  = nr_of(i);
      eov = m_busy[i] && (m_k[i] >= nr + 1);
      ek  = (m_busy[i] && nr - m_k[i] > 0) ? nr - m_k[i] : 0;
      chk("in_ready", i, in_ready_w[i], !m_busy[i]);
      chk("busy", i, busy_w[i], m_busy[i]);
      chk("out_valid", i, out_valid_w[i], eov);
      chk("key_idx", i, key_idx_w[i], ek);
      if (eov) chk("out_data", i, out_data_w[i], m_exp[i]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int i, input logic [0:127] d, output int acc);
    int n = 0;
    while (!in_ready_w[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_w[i]) chk("send_timeout", i, 0, 1);
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    acc = cyc + 1;
    @(negedge clk);
    in_valid[i] = 1'b0;
  endtask

  task automatic wait_ov(input int i, output int at);
    int n = 0;
    while (!out_valid_w[i] && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid_w[i]) chk("ov_timeout", i, 0, 1);
    at = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, at, n;
    logic [0:127] held;
    rst = 1'b1;
    in_valid = 2'b00;
    out_ready = 2'b11;
    in_data[0] = '0;
    in_data[1] = '0;
    expand(0, 4, KEY128);
    expand(1, 8, KEY256);
    chk("model_c1", 0, aes_decrypt(C1, 0), PT);
    chk("model_c3", 1, aes_decrypt(C3, 1), PT);
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 0, in_ready_w[0], 1'b1);
    chk("rst_state_out", 0, state_out_w[0], 128'h0);
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 C.1 with the key index trace and latency
    send(0, C1, acc);
    for (int t = 0; t < 12; t++) begin
      if (t > 0) @(negedge clk);
      chk("t1_trace_key", 0, key_idx_w[0], exp_trace[t]);
      chk("t1_trace_ov", 0, out_valid_w[0], (t == 11));
    end
    chk("t1_data", 0, out_data_w[0], PT);
    chk("t1_latency", 0, cyc - acc, 11);
    @(negedge clk);

    // FIPS-197 C.3 on the 14-round sequencer
    send(1, C3, acc);
    wait_ov(1, at);
    chk("t2_latency", 1, at - acc, 15);
    chk("t2_data", 1, out_data_w[1], PT);
    @(negedge clk);

    // Backpressure, ignored offers, and simultaneous release plus offer
    out_ready[0] = 1'b0;
    send(0, PT, acc);
    wait_ov(0, at);
    held = aes_decrypt(PT, 0);
    for (int t = 0; t < 20; t++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = C1;
      @(negedge clk);
      chk("t3_hold_data", 0, out_data_w[0], held);
      chk("t3_hold_ready", 0, in_ready_w[0], 1'b0);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("t3_idle_ready", 0, in_ready_w[0], 1'b1);
    chk("t3_idle_ov", 0, out_valid_w[0], 1'b0);
    @(negedge clk);
    in_valid[0] = 1'b0;
    chk("t3_accept_busy", 0, busy_w[0], 1'b1);
    chk("t3_accept_key", 0, key_idx_w[0], 4'd10);
    wait_ov(0, at);
    chk("t3_data", 0, out_data_w[0], PT);
    @(negedge clk);

    // Back-to-back blocks with out_ready held high
    send(0, C1, acc);
    send(0, 128'h3925841d02dc09fbdc118597196a0b32, acc2);
    chk("t4_spacing", 0, acc2 - acc, 13);
    wait_ov(0, at);
    chk("t4_data2", 0, out_data_w[0], aes_decrypt(128'h3925841d02dc09fbdc118597196a0b32, 0));
    @(negedge clk);

    // Asynchronous reset in the middle of ROUND
    send(0, C3, acc);
    n = 0;
    while (key_idx_w[0] != 4'd5 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reach_key5", 0, key_idx_w[0], 4'd5);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_in_ready", 0, in_ready_w[0], 1'b1);
    chk("t5_rst_busy", 0, busy_w[0], 1'b0);
    chk("t5_rst_ov", 0, out_valid_w[0], 1'b0);
    chk("t5_rst_key", 0, key_idx_w[0], 4'd0);
    chk("t5_rst_state", 0, state_out_w[0], 128'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_no_ov", 0, out_valid_w[0], 1'b0);
    send(0, C1, acc);
    wait_ov(0, at);
    chk("t5_latency", 0, at - acc, 11);
    chk("t5_data", 0, out_data_w[0], PT);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
